// File: rtl/hamming_enc_seq.sv
// -----------------------------------------------------------------------------
// hamming_enc_seq
//
// Memory-walking SECDED encoder. After a rising edge on `req` it reads NUM_MSG
// 11-bit messages from data memory (stored as lo/hi byte pairs starting at
// SRC_BASE), encodes each into a Hamming(15,11) codeword plus an overall
// parity bit, and writes the 16-bit result back as a byte pair starting at
// DST_BASE. `done` is a level that stays high until reset or the next start.
//
// Optional feature macro: HAMM_VERIFY_EN
//   When defined, every message gets two extra read-back states (VF_LO, VF_HI)
//   after the writes. Each re-read byte that differs from the computed value
//   bumps `err_cnt` (saturating at 255). When undefined, `err_cnt` is 0.
//
// Handshake: `req` is a start request. Only its rising edge matters, and only
// while the sequencer is in IDLE or DONE; edges seen while busy are dropped,
// never queued. `done` acknowledges completion as a level.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req        in   start request (rising edge significant)
//   done       out  run complete (level)
//   dm_addr    out  data-memory byte address (AW bits)
//   dm_wr_en   out  data-memory write strobe
//   dm_wr_data out  data-memory write byte
//   dm_rd_data in   combinational read data for dm_addr
//   err_cnt    out  read-back mismatch count (0 without HAMM_VERIFY_EN)
//   dbg_state  out  current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module hamming_enc_seq #(
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int NUM_MSG  = 15,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic [AW-1:0] dm_addr,
    output logic          dm_wr_en,
    output logic [7:0]    dm_wr_data,
    input  logic [7:0]    dm_rd_data,
    output logic [7:0]    err_cnt,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_VF_LO = 3'd5,
        S_VF_HI = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);
    localparam logic [6:0]    LAST_IDX = 7'(NUM_MSG - 1);
    localparam bit            NO_MSGS  = (NUM_MSG == 0);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [6:0]    idx_q, idx_d;
    // Message bits are numbered d[11:1] to match the parity equations.
    logic [11:1]   msg_q, msg_d;

    logic          start;
    logic          idle_or_done;
    logic [AW-1:0] idx_off;
    logic          p8, p4, p2, p1, p0;
    logic [7:0]    cw_lo, cw_hi;

    assign start        = req & ~req_q;
    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign idx_off      = AW'({idx_q, 1'b0});
    assign dbg_state    = state_q;
    assign done         = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Parity from the registered message
    // ------------------------------------------------------------------
    always_comb begin
        p8 = ^msg_q[11:5];
        p4 = (^msg_q[11:8]) ^ (^msg_q[4:2]);
        p2 = msg_q[11] ^ msg_q[10] ^ msg_q[7] ^ msg_q[6] ^ msg_q[4] ^ msg_q[3] ^ msg_q[1];
        p1 = msg_q[11] ^ msg_q[9] ^ msg_q[7] ^ msg_q[5] ^ msg_q[4] ^ msg_q[2] ^ msg_q[1];
        p0 = (^msg_q[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        cw_lo = {msg_q[4:2], p4, msg_q[1], p2, p1, p0};
        cw_hi = {msg_q[11:5], p8};
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = NO_MSGS ? S_DONE : S_RD_LO;
                end
            end
            S_RD_LO: state_d = S_RD_HI;
            S_RD_HI: state_d = S_WR_LO;
            S_WR_LO: state_d = S_WR_HI;
`ifdef HAMM_VERIFY_EN
            S_WR_HI: state_d = S_VF_LO;
            S_VF_LO: state_d = S_VF_HI;
            // The index was already advanced in WR_HI, so the last message
            // is recognised by idx_q having reached NUM_MSG.
            S_VF_HI: state_d = (idx_q == LAST_IDX + 7'd1) ? S_DONE : S_RD_LO;
`else
            S_WR_HI: state_d = (idx_q == LAST_IDX) ? S_DONE : S_RD_LO;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (memory port)
    // ------------------------------------------------------------------
`ifdef HAMM_VERIFY_EN
    logic [AW-1:0] prev_off;
    // Verify states run after the index increment, so they address the
    // previous message's codeword.
    assign prev_off = AW'({idx_q - 7'd1, 1'b0});
`endif

    always_comb begin
        dm_addr    = '0;
        dm_wr_en   = 1'b0;
        dm_wr_data = 8'h00;
        case (state_q)
            S_RD_LO: dm_addr = SRC_A + idx_off;
            S_RD_HI: dm_addr = SRC_A + idx_off + AW'(1);
            S_WR_LO: begin
                dm_addr    = DST_A + idx_off;
                dm_wr_en   = 1'b1;
                dm_wr_data = cw_lo;
            end
            S_WR_HI: begin
                dm_addr    = DST_A + idx_off + AW'(1);
                dm_wr_en   = 1'b1;
                dm_wr_data = cw_hi;
            end
`ifdef HAMM_VERIFY_EN
            S_VF_LO: dm_addr = DST_A + prev_off;
            S_VF_HI: dm_addr = DST_A + prev_off + AW'(1);
`endif
            default: ;
        endcase
        // Never let a stray write through while reset is asserted.
        if (reset) begin
            dm_wr_en = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: request edge detect, message index, message register
    // ------------------------------------------------------------------
    always_comb begin
        req_d = req;
        idx_d = idx_q;
        msg_d = msg_q;
        if (idle_or_done && start) begin
            idx_d = 7'd0;
        end
        case (state_q)
            S_RD_LO: msg_d[8:1]  = dm_rd_data;
            S_RD_HI: msg_d[11:9] = dm_rd_data[2:0];
            S_WR_HI: idx_d       = idx_q + 7'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 1'b0;
            idx_q <= 7'd0;
            msg_q <= '0;
        end else begin
            req_q <= req_d;
            idx_q <= idx_d;
            msg_q <= msg_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-back error counter
    // ------------------------------------------------------------------
`ifdef HAMM_VERIFY_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       vf_miss;

    always_comb begin
        vf_miss = 1'b0;
        if (state_q == S_VF_LO) begin
            vf_miss = (dm_rd_data != cw_lo);
        end else if (state_q == S_VF_HI) begin
            vf_miss = (dm_rd_data != cw_hi);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (idle_or_done && start) begin
            err_cnt_d = 8'd0;
        end else if (vf_miss && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hamming_enc_seq.sv
// -----------------------------------------------------------------------------
// Testbench for hamming_enc_seq. Provides a byte-wide memory with combinational
// read, loads message bytes, runs the sequencer and compares the written
// codewords with a reference encoder built from Hamming bit positions.
// -----------------------------------------------------------------------------
module tb_hamming_enc_seq;

  localparam int N   = 15;
  localparam int SRC = 0;
  localparam int DST = 30;
`ifdef HAMM_VERIFY_EN
  localparam int CPM = 6;
`else
  localparam int CPM = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req;
  logic       done;
  logic [7:0] dm_addr;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;
  logic [7:0] dm_rd_data;
  logic [7:0] err_cnt;
  logic [2:0] dbg_state;

  hamming_enc_seq #(
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .NUM_MSG (N),
    .AW      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .dm_addr   (dm_addr),
    .dm_wr_en  (dm_wr_en),
    .dm_wr_data(dm_wr_data),
    .dm_rd_data(dm_rd_data),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- memory ----------------
  logic [7:0] mem [0:255];
  logic       tb_wr;
  logic [7:0] tb_waddr;
  logic [7:0] tb_wdata;
  int         wr_cnt    = 0;
  int         stray_cnt = 0;

  assign dm_rd_data = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr_en) begin
      mem[dm_addr] <= dm_wr_data;
      wr_cnt <= wr_cnt + 1;
      if (int'(dm_addr) < DST || int'(dm_addr) >= DST + 2 * N)
        stray_cnt <= stray_cnt + 1;
    end else if (tb_wr) begin
      mem[tb_waddr] <= tb_wdata;
    end
  end

  // ---------------- scoreboard state ----------------
  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  logic [7:0] src_lo [N];
  logic [7:0] src_hi [N];

  // Reference encoder: data bits fill codeword positions that are not powers
  // of two (3,5,6,7,9..15), each parity at position p covers every position
  // whose index has bit p set, and position 0 holds overall parity.
  function automatic logic [15:0] ref_cw(input logic [10:0] d);
    logic [15:0] cw;
    logic        b;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) b = b ^ cw[pos];
      cw[p] = b;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    tb_wr    = 1'b1;
    tb_waddr = addr;
    tb_wdata = data;
    @(posedge clk);
    #1;
    tb_wr = 1'b0;
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < N; i++) begin
      src_lo[i] = 8'($urandom_range(0, 255));
      src_hi[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic write_sources();
    for (int i = 0; i < N; i++) begin
      poke(8'(SRC + 2 * i), src_lo[i]);
      poke(8'(SRC + 2 * i + 1), src_hi[i]);
    end
  endtask

  task automatic clear_dst();
    for (int i = 0; i < 2 * N; i++) poke(8'(DST + i), 8'hAA);
  endtask

  // Raise req, take E0, then count edges until done (bounded).
  task automatic start_run(input string tag, input bit hold, output int cyc);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_state_rd_lo"}, 16'(dbg_state), 16'd1);
    check({tag, "_done_low"}, 16'(done), 16'd0);
    cyc = 0;
    while (!done && cyc < CPM * N + 20) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_done_latency"}, 16'(cyc), 16'(CPM * N));
  endtask

  task automatic check_results(input string tag);
    logic [15:0] exp;
    for (int i = 0; i < N; i++) begin
      exp = ref_cw({src_hi[i][2:0], src_lo[i]});
      check($sformatf("%s_lo%0d", tag, i), 16'(mem[DST + 2 * i]), 16'(exp[7:0]));
      check($sformatf("%s_hi%0d", tag, i), 16'(mem[DST + 2 * i + 1]), 16'(exp[15:8]));
    end
    check({tag, "_err_cnt"}, 16'(err_cnt), 16'd0);
    check({tag, "_idle_addr"}, 16'(dm_addr), 16'd0);
    check({tag, "_idle_wdata"}, 16'(dm_wr_data), 16'd0);
    check({tag, "_idle_wr_en"}, 16'(dm_wr_en), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int wb;
    int held_bad;

    reset = 1'b1;
    req   = 1'b0;
    tb_wr = 1'b0;
    tb_waddr = 8'h00;
    tb_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 16'(dbg_state), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_wr_en", 16'(dm_wr_en), 16'd0);
    check("rst_addr", 16'(dm_addr), 16'd0);
    check("rst_wdata", 16'(dm_wr_data), 16'd0);
    check("rst_err_cnt", 16'(err_cnt), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // A: all-zero messages
    for (int i = 0; i < N; i++) begin
      src_lo[i] = 8'h00;
      src_hi[i] = 8'h00;
    end
    write_sources();
    clear_dst();
    wb = wr_cnt;
    start_run("zero", 1'b0, cyc);
    check_results("zero");
    check("zero_writes", 16'(wr_cnt - wb), 16'(2 * N));

    // B: directed corner messages plus random fill
    randomize_sources();
    src_lo[0] = 8'hFF; src_hi[0] = 8'h07;
    src_lo[1] = 8'h01; src_hi[1] = 8'h00;
    src_lo[2] = 8'h00; src_hi[2] = 8'hF8;
    write_sources();
    clear_dst();
    start_run("dir", 1'b0, cyc);
    check_results("dir");
    check("dir_7ff_lo", 16'(mem[DST]), 16'h00FF);
    check("dir_7ff_hi", 16'(mem[DST + 1]), 16'h00FF);
    check("dir_001_lo", 16'(mem[DST + 2]), 16'h000F);
    check("dir_001_hi", 16'(mem[DST + 3]), 16'h0000);
    check("dir_hi_ign_lo", 16'(mem[DST + 4]), 16'h0000);
    check("dir_hi_ign_hi", 16'(mem[DST + 5]), 16'h0000);

    // C: reset in the middle of a run, then a full fresh run
    randomize_sources();
    write_sources();
    clear_dst();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_wr_force", 16'(dm_wr_en), 16'd0);
    @(posedge clk);
    #1;
    check("midrst_state", 16'(dbg_state), 16'd0);
    check("midrst_done", 16'(done), 16'd0);
    check("midrst_wr_en", 16'(dm_wr_en), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_dst();
    wb = wr_cnt;
    start_run("after_rst", 1'b0, cyc);
    check_results("after_rst");
    check("after_rst_writes", 16'(wr_cnt - wb), 16'(2 * N));

    // D: req held high for 200 cycles yields one run
    randomize_sources();
    write_sources();
    clear_dst();
    wb = wr_cnt;
    start_run("held", 1'b1, cyc);
    held_bad = 0;
    for (int c = cyc + 1; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1) held_bad++;
    end
    check("held_done_stays", 16'(held_bad), 16'd0);
    check("held_writes", 16'(wr_cnt - wb), 16'(2 * N));
    check_results("held");
    @(negedge clk);
    req = 1'b0;
    clear_dst();
    wb = wr_cnt;
    start_run("rerun", 1'b0, cyc);
    check_results("rerun");
    check("rerun_writes", 16'(wr_cnt - wb), 16'(2 * N));

    // E: a req edge while busy is dropped
    randomize_sources();
    write_sources();
    clear_dst();
    wb = wr_cnt;
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (!done && cyc < CPM * N + 20) begin
      @(negedge clk);
      req = (cyc == 6);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_done_latency", 16'(cyc), 16'(CPM * N));
    @(negedge clk);
    req = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("busy_done_stays", 16'(done), 16'd1);
    check("busy_writes", 16'(wr_cnt - wb), 16'(2 * N));
    check_results("busy");

    check("stray_writes", 16'(stray_cnt), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
